// File: rtl/aq_biu_wt_ctrl.sv
// ---------------------------------------------------------------------------
// aq_biu_wt_ctrl
// Allocation and retirement controller for the BIU write table.
//
// Every accepted AW beat allocates the entry at create_ptr. Every B response
// retires the entry at pop_ptr. All writes share one AXI ID, so responses
// return in issue order and the table behaves as a FIFO. The block also
// OR-reduces the per-entry hit vectors into the AR/AW block signals, and it
// holds AW back while the table is full or an AW hit is pending.
//
// Handshake semantics: a transfer happens on a rising wtable_clk edge when
// valid and ready are both high in that cycle. Valid never depends on ready.
// Here awvalid is derived only from the raw request, the registered full flag
// and the block hits. A create is awvalid & awready. A pop is
// bvalid & bready while the table is not empty.
//
// Optional feature: define BIU_WT_TIMEOUT_EN to add a 12-bit age counter and
// the sticky wtable_timeout output port.
//
// Ports
//   wtable_clk, cpurst_b          clock; asynchronous active-low reset
//   biu_awvalid_raw, awready      ungated AW request; bus AW ready
//   awaddr, awcache, awlen        AW attributes captured by the created cell
//   bvalid, bready                B response handshake
//   wtable_entry_vld              per-entry valid bits from the cells
//   ar_/aw_hit_addr/so_vec        per-entry hit vectors from the cells
//   awvalid                       gated AW valid to the bus
//   wtable_create_en/pop_en       one-hot create / pop strobes
//   wtable_create_addr/so/burst   attributes for the cell being created
//   wtable_full, wtable_empty     occupancy flags from the registered count
//   ar_block, aw_block            combinational hit reductions
//   wtable_timeout                sticky age timeout (BIU_WT_TIMEOUT_EN only)
//   wtable_err                    sticky protocol error
// ---------------------------------------------------------------------------
module aq_biu_wt_ctrl #(
   parameter int ENTRY_NUM = 4,
   parameter int PTR_W     = 2,
   parameter int PADDR     = 40
) (
   input  logic                 wtable_clk,
   input  logic                 cpurst_b,
   input  logic                 biu_awvalid_raw,
   input  logic                 awready,
   input  logic [PADDR-1:0]     awaddr,
   input  logic [3:0]           awcache,
   input  logic [1:0]           awlen,
   input  logic                 bvalid,
   input  logic                 bready,
   input  logic [ENTRY_NUM-1:0] wtable_entry_vld,
   input  logic [ENTRY_NUM-1:0] ar_hit_addr_vec,
   input  logic [ENTRY_NUM-1:0] ar_hit_so_vec,
   input  logic [ENTRY_NUM-1:0] aw_hit_addr_vec,
   input  logic [ENTRY_NUM-1:0] aw_hit_so_vec,
   output logic                 awvalid,
   output logic [ENTRY_NUM-1:0] wtable_create_en,
   output logic [ENTRY_NUM-1:0] wtable_pop_en,
   output logic [9:0]           wtable_create_addr,
   output logic                 wtable_create_so,
   output logic                 wtable_create_burst,
   output logic                 wtable_full,
   output logic                 wtable_empty,
   output logic                 ar_block,
   output logic                 aw_block,
`ifdef BIU_WT_TIMEOUT_EN
   output logic                 wtable_timeout,
`endif
   output logic                 wtable_err
);

   localparam logic [PTR_W:0] CNT_FULL = (PTR_W+1)'(ENTRY_NUM);

   logic [PTR_W-1:0] create_ptr;
   logic [PTR_W-1:0] pop_ptr;
   logic [PTR_W:0]   cnt;
   logic [PTR_W:0]   cnt_nxt;
   logic             aw_hs;
   logic             pop_hs;
   logic             b_hs;
   logic             err_set;

   // Attribute bits the cells do not store; reduced here to mark them as
   // intentionally unused.
   logic unused_attr_bits;
   assign unused_attr_bits = ^{awaddr[PADDR-1:14], awaddr[3:0], awcache[3:2], awcache[0]};

   // Hits from the cells are already qualified with entry valid.
   assign ar_block = (|ar_hit_addr_vec) | (|ar_hit_so_vec);
   assign aw_block = (|aw_hit_addr_vec) | (|aw_hit_so_vec);

   // Full and empty come from the registered count. A pop in the same cycle
   // therefore cannot open the gate for a create while the table is full.
   assign wtable_full  = (cnt == CNT_FULL);
   assign wtable_empty = (cnt == '0);

   assign awvalid = biu_awvalid_raw & ~wtable_full & ~aw_block;
   assign aw_hs   = awvalid & awready;
   assign b_hs    = bvalid & bready;
   assign pop_hs  = b_hs & ~wtable_empty;

   assign wtable_create_addr  = awaddr[13:4];
   assign wtable_create_so    = ~awcache[1];
   assign wtable_create_burst = (awlen == 2'b11);

   // Strobes are combinational, so a cell captures its create or pop on the
   // same edge that moves the matching pointer.
   always_comb begin
      wtable_create_en          = '0;
      wtable_pop_en             = '0;
      wtable_create_en[create_ptr] = aw_hs;
      wtable_pop_en[pop_ptr]       = pop_hs;
   end

   always_comb begin
      cnt_nxt = cnt;
      case ({aw_hs, pop_hs})
         2'b10:   cnt_nxt = cnt + 1'b1;
         2'b01:   cnt_nxt = cnt - 1'b1;
         default: cnt_nxt = cnt;
      endcase
   end

   // Error sources: a B response with nothing outstanding, creating into a
   // cell that still holds an entry, or popping a cell that is not valid.
   assign err_set = (b_hs & wtable_empty)
                  | (aw_hs & wtable_entry_vld[create_ptr])
                  | (pop_hs & ~wtable_entry_vld[pop_ptr]);

   always_ff @(posedge wtable_clk or negedge cpurst_b) begin
      if (!cpurst_b) begin
         create_ptr <= '0;
         pop_ptr    <= '0;
         cnt        <= '0;
         wtable_err <= 1'b0;
      end else begin
         if (aw_hs)
            create_ptr <= create_ptr + PTR_W'(1);
         if (pop_hs)
            pop_ptr <= pop_ptr + PTR_W'(1);
         cnt <= cnt_nxt;
         if (err_set)
            wtable_err <= 1'b1;
      end
   end

`ifdef BIU_WT_TIMEOUT_EN
   // Age of the oldest outstanding write. It restarts whenever that entry
   // retires or nothing is outstanding, and saturates at all-ones.
   logic [11:0] age_cnt;

   always_ff @(posedge wtable_clk or negedge cpurst_b) begin
      if (!cpurst_b) begin
         age_cnt        <= '0;
         wtable_timeout <= 1'b0;
      end else begin
         if (pop_hs || wtable_empty)
            age_cnt <= '0;
         else if (age_cnt != 12'hFFF)
            age_cnt <= age_cnt + 12'd1;
         if (age_cnt == 12'hFFF)
            wtable_timeout <= 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_aq_biu_wt_ctrl.sv
// ---------------------------------------------------------------------------
// tb_aq_biu_wt_ctrl
// Directed bench for aq_biu_wt_ctrl with ENTRY_NUM=4.
//
// Inputs are driven 1 time unit after the rising edge and outputs are sampled
// on the falling edge. A small cell model keeps wtable_entry_vld consistent
// with the strobes. Expected create and pop strobes are queued when the
// stimulus is driven, and a monitor checks them when the DUT emits them.
// Build with BIU_WT_TIMEOUT_EN defined to include the age-timeout steps.
// ---------------------------------------------------------------------------
module tb_aq_biu_wt_ctrl;

   localparam int W = 16;

   logic        wtable_clk;
   logic        cpurst_b;
   logic        biu_awvalid_raw;
   logic        awready;
   logic [39:0] awaddr;
   logic [3:0]  awcache;
   logic [1:0]  awlen;
   logic        bvalid;
   logic        bready;
   logic [3:0]  wtable_entry_vld;
   logic [3:0]  ar_hit_addr_vec;
   logic [3:0]  ar_hit_so_vec;
   logic [3:0]  aw_hit_addr_vec;
   logic [3:0]  aw_hit_so_vec;
   logic        awvalid;
   logic [3:0]  wtable_create_en;
   logic [3:0]  wtable_pop_en;
   logic [9:0]  wtable_create_addr;
   logic        wtable_create_so;
   logic        wtable_create_burst;
   logic        wtable_full;
   logic        wtable_empty;
   logic        ar_block;
   logic        aw_block;
   logic        wtable_err;
`ifdef BIU_WT_TIMEOUT_EN
   logic        wtable_timeout;
`endif

   int errors = 0;
   int checks = 0;

   logic [W-1:0] exp_q[$];
   logic [3:0]   exp_pop_q[$];

   aq_biu_wt_ctrl #(.ENTRY_NUM(4), .PTR_W(2), .PADDR(40)) dut (
      .wtable_clk          (wtable_clk),
      .cpurst_b            (cpurst_b),
      .biu_awvalid_raw     (biu_awvalid_raw),
      .awready             (awready),
      .awaddr              (awaddr),
      .awcache             (awcache),
      .awlen               (awlen),
      .bvalid              (bvalid),
      .bready              (bready),
      .wtable_entry_vld    (wtable_entry_vld),
      .ar_hit_addr_vec     (ar_hit_addr_vec),
      .ar_hit_so_vec       (ar_hit_so_vec),
      .aw_hit_addr_vec     (aw_hit_addr_vec),
      .aw_hit_so_vec       (aw_hit_so_vec),
      .awvalid             (awvalid),
      .wtable_create_en    (wtable_create_en),
      .wtable_pop_en       (wtable_pop_en),
      .wtable_create_addr  (wtable_create_addr),
      .wtable_create_so    (wtable_create_so),
      .wtable_create_burst (wtable_create_burst),
      .wtable_full         (wtable_full),
      .wtable_empty        (wtable_empty),
      .ar_block            (ar_block),
      .aw_block            (aw_block),
`ifdef BIU_WT_TIMEOUT_EN
      .wtable_timeout      (wtable_timeout),
`endif
      .wtable_err          (wtable_err)
   );

   // ---------------- clock / reset ----------------
   initial wtable_clk = 1'b0;
   always #5 wtable_clk = ~wtable_clk;

   initial begin
      #300000;
      $display("FAIL watchdog: observed=run still active expected=finished");
      $fatal(1, "watchdog expired");
   end

   // Cell model: an entry becomes valid on its create strobe and clears on its pop.
   always @(posedge wtable_clk or negedge cpurst_b) begin
      if (!cpurst_b)
         wtable_entry_vld <= 4'b0;
      else
         wtable_entry_vld <= (wtable_entry_vld | wtable_create_en) & ~wtable_pop_en;
   end

   // ---------------- check / driver helpers ----------------
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [W-1:0] pk(input logic [3:0] en, input logic [39:0] addr,
                                       input logic so, input logic burst);
      return {en, addr[13:4], so, burst};
   endfunction

   task automatic tick();
      @(posedge wtable_clk);
      #1;
   endtask

   task automatic at_neg();
      @(negedge wtable_clk);
   endtask

   task automatic drive_aw(input logic [39:0] addr, input logic [3:0] cache,
                           input logic [1:0] len);
      biu_awvalid_raw = 1'b1;
      awaddr          = addr;
      awcache         = cache;
      awlen           = len;
   endtask

   task automatic drive_b(input logic v);
      bvalid = v;
      bready = v;
   endtask

   // ---------------- scoreboard monitor ----------------
   always @(negedge wtable_clk) begin
      if (cpurst_b) begin
         if (wtable_create_en !== 4'b0) begin
            if (exp_q.size() == 0)
               chk("create_unexpected", {28'b0, wtable_create_en}, 32'h0);
            else
               chk("create", {wtable_create_en, wtable_create_addr, wtable_create_so,
                              wtable_create_burst}, exp_q.pop_front());
         end
         if (wtable_pop_en !== 4'b0) begin
            if (exp_pop_q.size() == 0)
               chk("pop_unexpected", {28'b0, wtable_pop_en}, 32'h0);
            else
               chk("pop", {28'b0, wtable_pop_en}, {28'b0, exp_pop_q.pop_front()});
         end
      end
   end

   // ---------------- directed sequence ----------------
   initial begin
      cpurst_b        = 1'b0;
      biu_awvalid_raw = 1'b0;
      awready         = 1'b1;
      awaddr          = '0;
      awcache         = 4'b0010;
      awlen           = 2'b00;
      bvalid          = 1'b0;
      bready          = 1'b0;
      ar_hit_addr_vec = '0;
      ar_hit_so_vec   = '0;
      aw_hit_addr_vec = '0;
      aw_hit_so_vec   = '0;
      repeat (3) tick();
      cpurst_b = 1'b1;

      // Reset state
      at_neg();
      chk("rst_empty", wtable_empty, 1);
      chk("rst_full", wtable_full, 0);
      chk("rst_awvalid", awvalid, 0);
      chk("rst_err", wtable_err, 0);
      tick();

      // Fill all four entries
      for (int i = 0; i < 4; i++) begin
         drive_aw(40'h1000 + 40'(i * 16), 4'b0010, 2'b00);
         exp_q.push_back(pk(4'(1 << i), 40'h1000 + 40'(i * 16), 1'b0, 1'b0));
         at_neg();
         chk("fill_awvalid", awvalid, 1);
         tick();
      end
      at_neg();
      chk("full_flag", wtable_full, 1);
      chk("full_awvalid_gated", awvalid, 0);
      chk("full_not_empty", wtable_empty, 0);
      tick();

      // Pop while full with AW pending: no create that cycle, create next cycle
      drive_b(1'b1);
      exp_pop_q.push_back(4'b0001);
      at_neg();
      chk("full_pop_awvalid", awvalid, 0);
      tick();
      drive_b(1'b0);
      drive_aw(40'h1040, 4'b0010, 2'b00);
      exp_q.push_back(pk(4'b0001, 40'h1040, 1'b0, 1'b0));
      at_neg();
      chk("refill_awvalid", awvalid, 1);
      chk("refill_not_full", wtable_full, 0);
      tick();
      biu_awvalid_raw = 1'b0;
      at_neg();
      chk("refull_flag", wtable_full, 1);

      // Drain: pops at entries 1,2,3,0
      for (int j = 0; j < 4; j++) begin
         drive_b(1'b1);
         exp_pop_q.push_back(4'(1 << ((j + 1) % 4)));
         tick();
      end
      drive_b(1'b0);
      at_neg();
      chk("drain_empty", wtable_empty, 1);
      chk("drain_err", wtable_err, 0);
      tick();

      // Alternate create/pop, pointers wrap, count never above one
      for (int k = 0; k < 10; k++) begin
         drive_aw(40'h3000 + 40'(k * 16), 4'b0010, 2'b00);
         exp_q.push_back(pk(4'(1 << ((1 + k) % 4)), 40'h3000 + 40'(k * 16), 1'b0, 1'b0));
         tick();
         biu_awvalid_raw = 1'b0;
         drive_b(1'b1);
         exp_pop_q.push_back(4'(1 << ((1 + k) % 4)));
         at_neg();
         chk("alt_not_full", wtable_full, 0);
         chk("alt_not_empty", wtable_empty, 0);
         tick();
         drive_b(1'b0);
         at_neg();
         chk("alt_empty", wtable_empty, 1);
      end
      chk("alt_err", wtable_err, 0);
      tick();

      // Simultaneous create and pop leaves the count unchanged
      drive_aw(40'h3100, 4'b0010, 2'b00);
      exp_q.push_back(pk(4'b1000, 40'h3100, 1'b0, 1'b0));
      tick();
      drive_aw(40'h3110, 4'b0010, 2'b00);
      drive_b(1'b1);
      exp_q.push_back(pk(4'b0001, 40'h3110, 1'b0, 1'b0));
      exp_pop_q.push_back(4'b1000);
      tick();
      biu_awvalid_raw = 1'b0;
      exp_pop_q.push_back(4'b0001);
      at_neg();
      chk("both_cnt_kept", wtable_empty, 0);
      tick();
      drive_b(1'b0);
      at_neg();
      chk("both_empty", wtable_empty, 1);
      chk("both_err", wtable_err, 0);
      tick();

      // Strong-order burst create, then block reductions
      drive_aw(40'h2340, 4'b0000, 2'b11);
      exp_q.push_back(pk(4'b0010, 40'h2340, 1'b1, 1'b1));
      tick();
      drive_aw(40'h2350, 4'b0010, 2'b00);
      aw_hit_so_vec = 4'b0010;
      at_neg();
      chk("aw_block_so", aw_block, 1);
      chk("aw_block_awvalid", awvalid, 0);
      chk("ar_block_idle", ar_block, 0);
      tick();
      biu_awvalid_raw = 1'b0;
      aw_hit_so_vec   = 4'b0;
      ar_hit_addr_vec = 4'b0100;
      at_neg();
      chk("ar_block_addr", ar_block, 1);
      chk("aw_block_clear", aw_block, 0);
      tick();
      ar_hit_addr_vec = 4'b0;
      ar_hit_so_vec   = 4'b0001;
      aw_hit_addr_vec = 4'b1000;
      at_neg();
      chk("ar_block_so", ar_block, 1);
      chk("aw_block_addr", aw_block, 1);
      tick();
      ar_hit_so_vec   = 4'b0;
      aw_hit_addr_vec = 4'b0;
      drive_b(1'b1);
      exp_pop_q.push_back(4'b0010);
      tick();
      drive_b(1'b0);
      at_neg();
      chk("so_pop_empty", wtable_empty, 1);
      tick();

      // B response while empty: error, no pop
      drive_b(1'b1);
      at_neg();
      chk("empty_b_no_pop", wtable_pop_en, 0);
      tick();
      drive_b(1'b0);
      at_neg();
      chk("empty_b_err", wtable_err, 1);
      chk("empty_b_still_empty", wtable_empty, 1);
      repeat (3) tick();
      at_neg();
      chk("err_sticky", wtable_err, 1);
      tick();

      // Asynchronous reset mid-operation
      drive_aw(40'h5000, 4'b0010, 2'b00);
      exp_q.push_back(pk(4'b0100, 40'h5000, 1'b0, 1'b0));
      tick();
      biu_awvalid_raw = 1'b0;
      #2 cpurst_b = 1'b0;
      #1;
      chk("arst_empty", wtable_empty, 1);
      chk("arst_err", wtable_err, 0);
      tick();
      cpurst_b = 1'b1;
      drive_b(1'b1);
      at_neg();
      chk("arst_b_no_pop", wtable_pop_en, 0);
      tick();
      drive_b(1'b0);
      at_neg();
      chk("arst_b_err", wtable_err, 1);
      tick();
      drive_aw(40'h6000, 4'b0010, 2'b00);
      exp_q.push_back(pk(4'b0001, 40'h6000, 1'b0, 1'b0));
      tick();
      biu_awvalid_raw = 1'b0;
      drive_b(1'b1);
      exp_pop_q.push_back(4'b0001);
      at_neg();
      chk("arst_create_ptr0", wtable_empty, 0);
      tick();
      drive_b(1'b0);
      at_neg();
      chk("arst_pop_empty", wtable_empty, 1);
      tick();

`ifdef BIU_WT_TIMEOUT_EN
      // Age timeout on a single outstanding write
      #2 cpurst_b = 1'b0;
      tick();
      cpurst_b = 1'b1;
      drive_aw(40'h7000, 4'b0010, 2'b00);
      exp_q.push_back(pk(4'b0001, 40'h7000, 1'b0, 1'b0));
      tick();
      biu_awvalid_raw = 1'b0;
      repeat (4089) tick();
      at_neg();
      chk("timeout_early", wtable_timeout, 0);
      repeat (10) tick();
      at_neg();
      chk("timeout_set", wtable_timeout, 1);
      tick();
      drive_b(1'b1);
      exp_pop_q.push_back(4'b0001);
      tick();
      drive_b(1'b0);
      at_neg();
      chk("timeout_sticky", wtable_timeout, 1);
      chk("timeout_pop_empty", wtable_empty, 1);
      tick();
`endif

      // Every queued strobe must have been seen
      chk("create_q_drained", exp_q.size(), 0);
      chk("pop_q_drained", exp_pop_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/aq_biu_wt_ctrl.md
Name: aq_biu_wt_ctrl

Overview:
Allocation and retirement controller for the BIU write table, sitting in front of the per-entry write-table cells. Each accepted AW beat creates an entry; each B response retires the oldest entry, in FIFO order, because all writes use a single AXI ID. It OR-reduces the per-entry hit vectors into AR/AW block signals and gates AW issue when the table is full.

Parameters:
ENTRY_NUM, 4, number of write-table entries (power of 2, 2..8).
PTR_W, 2, log2(ENTRY_NUM).
PADDR, 40, physical address width.

Ports:
wtable_clk  in  1  controller clock.
cpurst_b  in  1  reset.
biu_awvalid_raw  in  1  AW request from the write path, before gating.
awready  in  1  bus AW ready.
awaddr  in  PADDR  AW address.
awcache  in  4  AW cache attributes.
awlen  in  2  AW burst length.
bvalid  in  1  bus B valid.
bready  in  1  B ready driven by the BIU.
wtable_entry_vld  in  ENTRY_NUM  per-entry valid bits from the cells.
ar_hit_addr_vec  in  ENTRY_NUM  per-entry AR address hits.
ar_hit_so_vec  in  ENTRY_NUM  per-entry AR strong-order hits.
aw_hit_addr_vec  in  ENTRY_NUM  per-entry AW address hits.
aw_hit_so_vec  in  ENTRY_NUM  per-entry AW strong-order hits.
awvalid  out  1  gated AW valid to the bus.
wtable_create_en  out  ENTRY_NUM  one-hot create strobe.
wtable_pop_en  out  ENTRY_NUM  one-hot pop strobe.
wtable_create_addr  out  10  awaddr[13:4].
wtable_create_so  out  1  !awcache[1].
wtable_create_burst  out  1  awlen==2'b11.
wtable_full  out  1  count==ENTRY_NUM.
wtable_empty  out  1  count==0.
ar_block  out  1  |ar_hit_addr_vec or |ar_hit_so_vec.
aw_block  out  1  |aw_hit_addr_vec or |aw_hit_so_vec.
wtable_err  out  1  sticky protocol error.

Behaviour:
- Interface: reset cpurst_b, asynchronous, active-low; clock wtable_clk.
- Registered state:
  - create_ptr, pop_ptr (PTR_W bits, wrap modulo ENTRY_NUM).
  - cnt (PTR_W+1 bits).
  - wtable_err.
  - All reset to 0; out of reset wtable_empty=1, wtable_full=0, awvalid=0.
- Gating: awvalid = biu_awvalid_raw & !wtable_full & !aw_block. A create is aw_hs = awvalid & awready.
- Create strobe: wtable_create_en[create_ptr] = aw_hs, combinational, so the cell captures it at the same edge. create_ptr increments on that edge.
- Retire: pop_hs = bvalid & bready & !wtable_empty. wtable_pop_en[pop_ptr] = pop_hs, combinational; pop_ptr increments on that edge.
- Count update:
  - cnt +1 on aw_hs only.
  - cnt -1 on pop_hs only.
  - Unchanged when both occur in the same cycle.
- Full/empty: computed from registered cnt. When full, a same-cycle pop does not unblock AW; the create occurs at the earliest the next cycle.
- Errors (wtable_err set, cleared only by reset):
  - bvalid & bready while empty. No pop strobe; pointers and cnt unchanged.
  - Strobed entry mismatch: wtable_entry_vld[create_ptr]=1 at create, or wtable_entry_vld[pop_ptr]=0 at pop.
- Block outputs: ar_block and aw_block are purely combinational with zero latency. The cells already qualify hits with entry valid.
- Reset mid-operation: all pointers, cnt and the error flag return to 0 asynchronously. In-flight B responses after reset count as empty-pop errors.

Optional Feature:
Macro BIU_WT_TIMEOUT_EN.
- When defined:
  - A 12-bit age counter clears on every pop_hs and whenever the table is empty.
  - It otherwise increments each cycle, saturating at 12'hFFF.
  - On reaching 12'hFFF it sets a sticky output wtable_timeout (extra 1-bit port), cleared by reset only.
- When undefined: the counter and port are absent, with no other behavioural change.

Test Plan:
- Reset, then four AW handshakes at awaddr 0x1000, 0x1010, 0x1020, 0x1030 with awready=1 -> create_en 0001/0010/0100/1000, create_addr 0x100..0x103, wtable_full=1, awvalid=0 while raw=1.
- Full table; bvalid=bready=1 and raw AW in the same cycle -> pop_en=0001, no create that cycle, create into entry 0 next cycle, cnt stays 4.
- Alternate create/pop over 10 transactions -> pointers wrap 3->0, cnt never exceeds 1, wtable_err=0.
- bvalid=bready=1 with the table empty -> pop_en=0, cnt=0, wtable_err=1 and it stays 1.
- awcache=4'b0000 and awlen=2'b11 -> create_so=1, create_burst=1; drive aw_hit_so_vec=0010 -> aw_block=1, awvalid=0.
- BIU_WT_TIMEOUT_EN defined; one create, no B for 4095 cycles -> wtable_timeout=1; a subsequent pop does not clear it.
